music_player: RTL and testbench

MUSIC_PLAYER -- requirements
Module: music_player

---
 rtl/music_player.sv | 140 ++++++++++++++
 tb/tb_music_player.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/music_player.sv
// Square-wave music player: four 16-note songs from an internal ROM, stepped by beat ticks
// derived from codec new_frame pulses, with play/pause, next-song, fast-forward and reverse.
module music_player #(
    parameter int BEAT_COUNT = 1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               play_button,
    input  logic               next_button,
    input  logic [1:0]         weight,
    input  logic               new_frame,
    input  logic               ff_switch0,
    input  logic               r_switch1,
    output logic signed [15:0] sample_out,
    output logic [1:0]         current_song,
    output logic               play
);

    localparam int BW = $clog2(BEAT_COUNT + 1);
    localparam logic [BW-1:0] LIM_NORM = BW'(BEAT_COUNT - 1);
    localparam logic [BW-1:0] LIM_FAST = BW'(BEAT_COUNT / 2 - 1);

    logic               play_q, play_d;
    logic [1:0]         song_q, song_d;
    logic [3:0]         idx_q, idx_d;
    logic [BW-1:0]      beat_q, beat_d;
    logic [1:0]         dur_q, dur_d;
    logic [19:0]        phase_q, phase_d;
    logic signed [15:0] sample_q, sample_d;
    logic               pb_prev_q, nb_prev_q;

    logic               play_edge, next_edge;
    logic [5:0]         pitch;
    logic [BW-1:0]      beat_lim;
    logic [19:0]        phase_next;

    function automatic logic [5:0] note_pitch(input logic [1:0] s, input logic [3:0] i);
        return 6'd8 + {2'b00, s, 2'b00} + {2'b00, i};
    endfunction

    function automatic logic [1:0] note_beats(input logic [1:0] s, input logic [3:0] i);
        logic unused;
        unused = ^{s, i};
        return 2'd2;
    endfunction

    function automatic logic signed [15:0] square_sample(input logic neg, input logic [1:0] w);
        logic signed [15:0] mag;
        mag = 16'sh4000 >>> w;
        return neg ? -mag : mag;
    endfunction

    always_comb begin
        play_d   = play_q;
        song_d   = song_q;
        idx_d    = idx_q;
        beat_d   = beat_q;
        dur_d    = dur_q;
        phase_d  = phase_q;
        sample_d = sample_q;

        play_edge  = play_button & ~pb_prev_q;
        next_edge  = next_button & ~nb_prev_q;
        pitch      = note_pitch(song_q, idx_q);
        beat_lim   = ff_switch0 ? LIM_FAST : LIM_NORM;
        phase_next = phase_q + {6'd0, pitch, 8'd0};

        if (play_edge) play_d = ~play_q;
        if (!play_q)   sample_d = '0;

        if (play_q && new_frame) begin
            phase_d  = phase_next;
            sample_d = square_sample(phase_next[19], weight);
            if (beat_q >= beat_lim) begin
                beat_d = '0;
                if (dur_q >= note_beats(song_q, idx_q) - 2'd1) begin
                    dur_d = '0;
                    if (!r_switch1) begin
                        if (idx_q == 4'd15) begin
                            // Song end: stop and queue up the next song from its start.
                            play_d   = 1'b0;
                            song_d   = song_q + 2'd1;
                            idx_d    = '0;
                            phase_d  = '0;
                            sample_d = '0;
                        end else begin
                            idx_d = idx_q + 4'd1;
                        end
                    end else if (idx_q != 4'd0) begin
                        idx_d = idx_q - 4'd1;
                    end
                end else begin
                    dur_d = dur_q + 2'd1;
                end
            end else begin
                beat_d = beat_q + BW'(1);
            end
        end

        // Next-song wins over everything else happening this cycle, including a play press.
        if (next_edge) begin
            song_d   = song_q + 2'd1;
            idx_d    = '0;
            beat_d   = '0;
            dur_d    = '0;
            phase_d  = '0;
            play_d   = 1'b0;
            sample_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            play_q    <= 1'b0;
            song_q    <= '0;
            idx_q     <= '0;
            beat_q    <= '0;
            dur_q     <= '0;
            phase_q   <= '0;
            sample_q  <= '0;
            pb_prev_q <= 1'b0;
            nb_prev_q <= 1'b0;
        end else begin
            play_q    <= play_d;
            song_q    <= song_d;
            idx_q     <= idx_d;
            beat_q    <= beat_d;
            dur_q     <= dur_d;
            phase_q   <= phase_d;
            sample_q  <= sample_d;
            pb_prev_q <= play_button;
            nb_prev_q <= next_button;
        end
    end

    assign play         = play_q;
    assign current_song = song_q;
    assign sample_out   = sample_q;

endmodule

// File: tb/tb_music_player.sv
// Randomized-timing bench for music_player with a song-level reference model.
module tb_music_player;

    localparam int BC = 100;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               play_button = 1'b0;
    logic               next_button = 1'b0;
    logic [1:0]         weight = 2'd0;
    logic               new_frame = 1'b0;
    logic               ff_switch0 = 1'b0;
    logic               r_switch1 = 1'b0;
    logic signed [15:0] sample_out;
    logic [1:0]         current_song;
    logic               play;

    int checks = 0;
    int failures = 0;

    // Reference model state: song/note position, frames into the current beat,
    // beats completed on the current note, phase, and expected sample.
    bit m_play, m_pb, m_nb;
    int m_song, m_idx, m_beat, m_beats, m_phase, m_sample;

    music_player #(.BEAT_COUNT(BC)) dut (
        .clk(clk), .reset(reset), .play_button(play_button), .next_button(next_button),
        .weight(weight), .new_frame(new_frame), .ff_switch0(ff_switch0), .r_switch1(r_switch1),
        .sample_out(sample_out), .current_song(current_song), .play(play)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        m_play = 0; m_pb = 0; m_nb = 0;
        m_song = 0; m_idx = 0; m_beat = 0; m_beats = 0; m_phase = 0; m_sample = 0;
    endtask

    task automatic model_restart_song();
        m_idx = 0; m_beat = 0; m_beats = 0; m_phase = 0; m_sample = 0; m_play = 0;
    endtask

    task automatic model_step();
        bit pe, ne, was_play;
        int mag, frames_per_beat;
        pe = play_button && !m_pb;
        ne = next_button && !m_nb;
        m_pb = play_button;
        m_nb = next_button;
        was_play = m_play;
        if (ne) begin
            m_song = (m_song + 1) % 4;
            model_restart_song();
            return;
        end
        if (pe) m_play = !m_play;
        if (!was_play) m_sample = 0;
        if (was_play && new_frame) begin
            m_phase = (m_phase + (8 + 4 * m_song + m_idx) * 256) % (1 << 20);
            mag = 16384 >> weight;
            m_sample = (m_phase >= (1 << 19)) ? -mag : mag;
            frames_per_beat = ff_switch0 ? BC / 2 : BC;
            m_beat++;
            if (m_beat >= frames_per_beat) begin
                m_beat = 0;
                m_beats++;
                if (m_beats == 2) begin
                    m_beats = 0;
                    if (r_switch1) begin
                        if (m_idx > 0) m_idx--;
                    end else if (m_idx == 15) begin
                        m_song = (m_song + 1) % 4;
                        model_restart_song();
                    end else begin
                        m_idx++;
                    end
                end
            end
        end
    endtask

    task automatic tick(input bit nf);
        new_frame = nf;
        model_step();
        @(posedge clk);
        #1;
        new_frame = 1'b0;
    endtask

    task automatic frame1();
        repeat ($urandom_range(0, 2)) tick(0);
        tick(1);
    endtask

    task automatic press_play(input int hold);
        play_button = 1'b1;
        repeat (hold) tick(0);
        play_button = 1'b0;
        tick(0);
    endtask

    task automatic press_next(input int hold);
        next_button = 1'b1;
        repeat (hold) tick(0);
        next_button = 1'b0;
        tick(0);
    endtask

    task automatic do_reset();
        play_button = 0; next_button = 0; new_frame = 0;
        weight = 0; ff_switch0 = 0; r_switch1 = 0;
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (play !== 1'b0 || current_song !== 2'd0 || sample_out !== 16'sd0) begin
            failures++;
            $display("FAIL reset_state: play=%0b song=%0d sample=%0d expected 0 0 0", play, current_song, sample_out);
        end
        repeat (5) tick(1);
        checks++;
        if (play !== 1'b0 || sample_out !== 16'sd0) begin
            failures++;
            $display("FAIL idle_after_reset: play=%0b sample=%0d expected 0 0", play, sample_out);
        end
    endtask

    task automatic test_play_first_notes();
        play_button = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick(0);
            checks++;
            if (play !== 1'b1) begin
                failures++;
                $display("FAIL play_hold cycle %0d: play=%0b expected 1", c, play);
            end
        end
        play_button = 1'b0;
        tick(0);
        for (int k = 1; k <= 256; k++) begin
            frame1();
            checks++;
            if (play !== m_play || current_song !== 2'(m_song) || sample_out !== 16'(m_sample)) begin
                failures++;
                $display("FAIL song0_frame %0d: play=%0b song=%0d sample=%0d expected %0b %0d %0d",
                         k, play, current_song, sample_out, m_play, m_song, m_sample);
            end
            if (k == 1 || k == 256) begin
                checks++;
                if (sample_out !== (k == 1 ? 16'sd16384 : -16'sd16384)) begin
                    failures++;
                    $display("FAIL song0_sample_at_%0d: sample=%0d expected %0d", k, sample_out, k == 1 ? 16384 : -16384);
                end
            end
        end
    endtask

    task automatic test_song_end();
        for (int k = 257; k <= 3200; k++) begin
            frame1();
            checks++;
            if (play !== m_play || current_song !== 2'(m_song) || sample_out !== 16'(m_sample)) begin
                failures++;
                $display("FAIL song_end_frame %0d: play=%0b song=%0d sample=%0d expected %0b %0d %0d",
                         k, play, current_song, sample_out, m_play, m_song, m_sample);
            end
            if (k == 3199 || k == 3200) begin
                checks++;
                if (play !== (k == 3199) || current_song !== (k == 3199 ? 2'd0 : 2'd1)) begin
                    failures++;
                    $display("FAIL song_end_at_%0d: play=%0b song=%0d", k, play, current_song);
                end
            end
        end
        tick(1);
        checks++;
        if (sample_out !== 16'sd0 || play !== 1'b0) begin
            failures++;
            $display("FAIL stopped_after_end: sample=%0d play=%0b expected 0 0", sample_out, play);
        end
    endtask

    task automatic test_next_button();
        do_reset();
        press_play(1);
        repeat (50) frame1();
        press_next(3);
        checks++;
        if (current_song !== 2'd1 || play !== 1'b0 || sample_out !== 16'sd0) begin
            failures++;
            $display("FAIL next_while_playing: song=%0d play=%0b sample=%0d expected 1 0 0", current_song, play, sample_out);
        end
        press_play(2);
        for (int k = 1; k <= 180; k++) begin
            frame1();
            checks++;
            if (play !== m_play || current_song !== 2'(m_song) || sample_out !== 16'(m_sample)) begin
                failures++;
                $display("FAIL song1_frame %0d: play=%0b song=%0d sample=%0d expected %0b %0d %0d",
                         k, play, current_song, sample_out, m_play, m_song, m_sample);
            end
            if (k == 1 || k == 170 || k == 171) begin
                checks++;
                if (sample_out !== (k == 171 ? -16'sd16384 : 16'sd16384)) begin
                    failures++;
                    $display("FAIL pitch12_sample_at_%0d: sample=%0d expected %0d", k, sample_out, k == 171 ? -16384 : 16384);
                end
            end
        end
    endtask

    task automatic test_pause();
        press_play(1);
        checks++;
        if (play !== 1'b0 || sample_out !== 16'sd0) begin
            failures++;
            $display("FAIL pause: play=%0b sample=%0d expected 0 0", play, sample_out);
        end
        repeat (20) frame1();
        press_play(4);
        for (int k = 1; k <= 60; k++) begin
            frame1();
            checks++;
            if (play !== m_play || current_song !== 2'(m_song) || sample_out !== 16'(m_sample)) begin
                failures++;
                $display("FAIL resume_frame %0d: play=%0b song=%0d sample=%0d expected %0b %0d %0d",
                         k, play, current_song, sample_out, m_play, m_song, m_sample);
            end
        end
    endtask

    task automatic test_weight();
        do_reset();
        press_play(1);
        weight = 2'd2;
        for (int k = 1; k <= 300; k++) begin
            if (k > 100) weight = 2'($urandom_range(0, 3));
            frame1();
            checks++;
            if (sample_out !== 16'(m_sample) || (k <= 100 && sample_out !== 16'sd4096 && sample_out !== -16'sd4096)) begin
                failures++;
                $display("FAIL weight_frame %0d: sample=%0d expected %0d (weight %0d)", k, sample_out, m_sample, weight);
            end
        end
        weight = 2'd0;
    endtask

    task automatic test_fast_forward();
        do_reset();
        press_play(1);
        ff_switch0 = 1'b1;
        for (int k = 1; k <= 1600; k++) begin
            frame1();
            checks++;
            if (play !== m_play || current_song !== 2'(m_song) || sample_out !== 16'(m_sample)) begin
                failures++;
                $display("FAIL ff_frame %0d: play=%0b song=%0d sample=%0d expected %0b %0d %0d",
                         k, play, current_song, sample_out, m_play, m_song, m_sample);
            end
            if (k == 1599 || k == 1600) begin
                checks++;
                if (play !== (k == 1599) || current_song !== (k == 1599 ? 2'd0 : 2'd1)) begin
                    failures++;
                    $display("FAIL ff_song_end_at_%0d: play=%0b song=%0d", k, play, current_song);
                end
            end
        end
        ff_switch0 = 1'b0;
    endtask

    task automatic test_reverse();
        do_reset();
        press_play(1);
        for (int k = 1; k <= 1600; k++) begin
            if (k == 601) r_switch1 = 1'b1;
            frame1();
            checks++;
            if (play !== m_play || current_song !== 2'(m_song) || sample_out !== 16'(m_sample)) begin
                failures++;
                $display("FAIL reverse_frame %0d: play=%0b song=%0d sample=%0d expected %0b %0d %0d",
                         k, play, current_song, sample_out, m_play, m_song, m_sample);
            end
        end
        checks++;
        if (play !== 1'b1 || current_song !== 2'd0 || m_idx != 0) begin
            failures++;
            $display("FAIL reverse_hold_at_0: play=%0b song=%0d expected 1 0", play, current_song);
        end
        r_switch1 = 1'b0;
    endtask

    task automatic test_song_wrap();
        do_reset();
        repeat (3) press_next(1);
        for (int n = 1; n <= 4; n++) begin
            press_next($urandom_range(1, 4));
            checks++;
            if (current_song !== 2'((3 + n) % 4) || play !== 1'b0) begin
                failures++;
                $display("FAIL wrap_press_%0d: song=%0d play=%0b expected %0d 0", n, current_song, play, (3 + n) % 4);
            end
        end
    endtask

    task automatic test_reset_mid_song();
        do_reset();
        press_next(1);
        press_play(1);
        repeat (300) frame1();
        checks++;
        if (play !== 1'b1 || current_song !== 2'd1 || sample_out === 16'sd0) begin
            failures++;
            $display("FAIL pre_reset_playing: play=%0b song=%0d sample=%0d", play, current_song, sample_out);
        end
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (play !== 1'b0 || current_song !== 2'd0 || sample_out !== 16'sd0) begin
            failures++;
            $display("FAIL async_reset: play=%0b song=%0d sample=%0d expected 0 0 0", play, current_song, sample_out);
        end
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (10) frame1();
        checks++;
        if (play !== 1'b0 || sample_out !== 16'sd0) begin
            failures++;
            $display("FAIL idle_after_mid_reset: play=%0b sample=%0d expected 0 0", play, sample_out);
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_play_first_notes();
        test_song_end();
        test_next_button();
        test_pause();
        test_weight();
        test_fast_forward();
        test_reverse();
        test_song_wrap();
        test_reset_mid_song();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
